if_stage: RTL
=============

# if_stage

Instruction-fetch stage: holds the architectural fetch PC, issues one-outstanding-request fetches to instruction memory, and drives the IF/ID pipeline register. It sits directly upstream of the next-PC unit, supplying the current `pc`. It consumes that unit's computed target through `redirect`/`redirect_pc` when a branch or jump resolves. A one-entry skid buffer absorbs a fetch response that arrives while decode is stalled.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch PC loaded on reset; bits [1:0] must be 0.
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `redirect` in 1: taken branch, jal or jalr resolved; flush and refetch.
- `redirect_pc` in 32: target from the next-PC unit's `npc` output; bits [1:0] cleared on load.
- `stall` in 1: ID cannot accept; hold IF/ID contents.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: fetch address; equals `pc`.
- `imem_gnt` in 1: request accepted this cycle, sampled only while `imem_req`=1.
- `imem_rvalid` in 1: response valid, at least 1 cycle after grant.
- `imem_rdata` in 32: instruction word.
- `pc` out 32: address of the fetch in flight; feeds the next-PC unit.
- `id_pc` out 32, `id_inst` out 32, `id_valid` out 1: IF/ID register.

## Operation
- States: IDLE (reset only), REQ, WAIT, FULL; plus a `kill` flag and a buffer (`buf_inst`).
- IDLE: `imem_req`=0; go to REQ unconditionally on the next cycle.
- REQ: `imem_req`=1, `imem_addr`=`pc`. On `imem_gnt`, go to WAIT.
- WAIT, on `imem_rvalid`:
  - `kill`=1: discard the data, clear `kill`, go to REQ.
  - otherwise, `stall`=0: load `id_pc`←`pc`, `id_inst`←`imem_rdata`, `id_valid`←1, `pc`←`pc`+4, go to REQ.
  - otherwise, `stall`=1: `buf_inst`←`imem_rdata`, go to FULL.
- FULL: when `stall`=0, move the buffer into IF/ID (`id_pc`←`pc`), set `pc`←`pc`+4, go to REQ.
- Bubble: when `stall`=0 and no instruction loads this cycle, `id_valid`←0; `id_pc`/`id_inst` are don't-care.
- Stall held: `id_*` unchanged; `pc` unchanged.
- Redirect has priority over `stall` and over every other event. On `redirect`=1:
  - `pc`←{`redirect_pc`[31:2],2'b00}; `id_valid`←0; buffer dropped.
  - REQ without `gnt`: stay in REQ (new address is presented from the next cycle).
  - REQ with `gnt` the same cycle: go to WAIT with `kill`=1.
  - WAIT without `rvalid`: stay in WAIT, `kill`←1.
  - WAIT with `rvalid`: discard the data, go to REQ.
  - FULL: go to REQ.
- `pc`+4 wraps modulo 2^32 (0xFFFF_FFFC → 0x0000_0000).
- At most one outstanding request; a new `imem_req` is never asserted in WAIT or FULL.

## Timing
- Reset (async): state IDLE, `pc`=RESET_PC, `imem_req`=0, `imem_addr`=RESET_PC, `id_valid`=0, `id_pc`=0, `id_inst`=32'h0000_0013 (nop), `kill`=0.
- Reset asserted mid-fetch: any in-flight response is ignored because the state is IDLE; the memory side must be reset together with this block.
- Zero-wait memory (`gnt` in the REQ cycle, `rvalid` one cycle later): `id_valid` rises 2 cycles after the REQ cycle; peak throughput is 1 instruction per 2 cycles.
- `imem_req`, `imem_addr` and `pc` are stable while in REQ until `gnt` or `redirect`.
- Redirect in cycle t: `pc` holds the new target at t+1; `id_valid`=0 at t+1; the first redirected instruction reaches ID no earlier than t+3.
- Outputs are registered, except `imem_req`/`imem_addr`, which decode from state and `pc`.

## Test plan
- Reset, zero-wait memory returning 0x0000_0013 for every address → `imem_addr` goes 0x0, 0x4, 0x8; `id_pc` goes 0x0, 0x4, 0x8, with `id_valid` pulsing every 2nd cycle.
- `stall`=1 for 4 cycles while the 0x8 response returns → state FULL; `id_pc` held at 0x4; after release, `id_pc`=0x8 and `id_inst` equals the buffered word; no request is issued during FULL.
- `redirect`=1 with `redirect_pc`=0x100 while in WAIT (response delayed 3 cycles) → the stale response is discarded, next `imem_addr`=0x100, and `id_pc`=0x100 is the first valid instruction after the flush.
- `redirect` coinciding with `gnt` in REQ, `redirect_pc`=0x200 → one killed response, then a request at 0x200; `redirect_pc`=0x203 → `imem_addr`=0x200.
- `redirect` and `stall` together in FULL → `id_valid`=0 next cycle; buffer dropped; REQ at the new target.
- RESET_PC=32'hFFFF_FFFC → second fetch address is 0x0; `rst` asserted while in WAIT, followed by a late `rvalid` → no `id_valid`; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus: one-outstanding request/grant, response valid/data.
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: fetch PC, single-outstanding imem fetch, one-entry skid
// buffer and the IF/ID pipeline register.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    if_stage_if.master   imem,
    input  logic         redirect,
    input  logic [31:0]  redirect_pc,
    input  logic         stall,
    output logic [31:0]  pc,
    output logic [31:0]  id_pc,
    output logic [31:0]  id_inst,
    output logic         id_valid
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, FULL} state_t;

    state_t      state;
    logic        kill;
    logic [31:0] buf_inst;
    logic [31:0] target;

    assign target         = redirect_pc & 32'hFFFF_FFFC;
    assign imem.imem_req  = (state == REQ);
    assign imem.imem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            kill     <= 1'b0;
            buf_inst <= '0;
            id_valid <= 1'b0;
            id_pc    <= '0;
            id_inst  <= 32'h0000_0013;
        end else if (redirect) begin
            pc       <= target;
            id_valid <= 1'b0;
            unique case (state)
                IDLE: state <= REQ;
                REQ: begin
                    // request granted at the old address: its response must be dropped
                    if (imem.imem_gnt) begin
                        state <= WAIT;
                        kill  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (imem.imem_rvalid) begin
                        state <= REQ;
                        kill  <= 1'b0;
                    end else begin
                        kill  <= 1'b1;
                    end
                end
                FULL: state <= REQ;
                default: state <= IDLE;
            endcase
        end else begin
            if (!stall) id_valid <= 1'b0;
            unique case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (imem.imem_gnt) state <= WAIT;
                end
                WAIT: begin
                    if (imem.imem_rvalid) begin
                        if (kill) begin
                            kill  <= 1'b0;
                            state <= REQ;
                        end else if (!stall) begin
                            id_pc    <= pc;
                            id_inst  <= imem.imem_rdata;
                            id_valid <= 1'b1;
                            pc       <= pc + 32'd4;
                            state    <= REQ;
                        end else begin
                            buf_inst <= imem.imem_rdata;
                            state    <= FULL;
                        end
                    end
                end
                FULL: begin
                    if (!stall) begin
                        id_pc    <= pc;
                        id_inst  <= buf_inst;
                        id_valid <= 1'b1;
                        pc       <= pc + 32'd4;
                        state    <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
